// File: rtl/alu_stream_pkg.sv
// Shared opcode encoding and generator widths for the alu_stream block.
package alu_stream_pkg;

    localparam int unsigned OP_WIDTH    = 4;
    localparam int unsigned OPCNT_WIDTH = 3;

    localparam logic [OP_WIDTH-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_WIDTH-1:0] OP_SUB  = 4'd1;
    localparam logic [OP_WIDTH-1:0] OP_AND  = 4'd2;
    localparam logic [OP_WIDTH-1:0] OP_OR   = 4'd3;
    localparam logic [OP_WIDTH-1:0] OP_XOR  = 4'd4;
    localparam logic [OP_WIDTH-1:0] OP_SHL  = 4'd5;
    localparam logic [OP_WIDTH-1:0] OP_SHR  = 4'd6;
    localparam logic [OP_WIDTH-1:0] OP_SLTU = 4'd7;

endpackage

// File: rtl/alu_stream_core.sv
// Combinational ALU: result and status flag for one operand pair.
module alu_stream_core
    import alu_stream_pkg::*;
#(
    parameter int unsigned data_width = 32
) (
    input  logic [data_width-1:0] a,
    input  logic [data_width-1:0] b,
    input  logic [OP_WIDTH-1:0]   op,
    output logic [data_width-1:0] r,
    output logic                  flag
);

    logic [data_width:0] sum;
    logic [data_width:0] diff;
    logic [4:0]          shamt;
    logic                shift_oob;
    logic                chk_zero;

    assign sum   = {1'b0, a} + {1'b0, b};
    // Top bit of the widened difference is the unsigned borrow (a < b).
    assign diff  = {1'b0, a} - {1'b0, b};
    // Only five shift bits are honoured whatever the data width.
    assign shamt = b[4:0];
    assign shift_oob = 32'(shamt) >= data_width;

    // Decode the opcode into result and flag; logic ops flag a zero result.
    always_comb begin
        r        = '0;
        flag     = 1'b0;
        chk_zero = 1'b0;
        case (op)
            OP_ADD: begin
                r    = sum[data_width-1:0];
                flag = sum[data_width];
            end
            OP_SUB: begin
                r    = diff[data_width-1:0];
                flag = diff[data_width];
            end
            OP_AND: begin
                r        = a & b;
                chk_zero = 1'b1;
            end
            OP_OR: begin
                r        = a | b;
                chk_zero = 1'b1;
            end
            OP_XOR: begin
                r        = a ^ b;
                chk_zero = 1'b1;
            end
            OP_SHL: begin
                r        = shift_oob ? '0 : (a << shamt);
                chk_zero = 1'b1;
            end
            OP_SHR: begin
                r        = shift_oob ? '0 : (a >> shamt);
                chk_zero = 1'b1;
            end
            OP_SLTU: begin
                r    = {{(data_width-1){1'b0}}, diff[data_width]};
                flag = (a == b);
            end
            default: begin
                r    = '0;
                flag = 1'b1;
            end
        endcase
        if (chk_zero) begin
            flag = (r == '0);
        end
    end

endmodule

// File: rtl/alu_stream.sv
// Operand source select, pipelined ALU with backpressure, and flag counter.
module alu_stream
    import alu_stream_pkg::*;
#(
    parameter int unsigned data_width  = 32,
    parameter int unsigned pipe_stages = 2,
    parameter int unsigned seed        = 1,
    parameter int unsigned cnt_width   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  gen_en,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [data_width-1:0] in_a,
    input  logic [data_width-1:0] in_b,
    input  logic [OP_WIDTH-1:0]   in_op,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [data_width-1:0] R,
    output logic                  flag,
    output logic [cnt_width-1:0]  flag_count
);

    localparam logic [data_width-1:0] SeedInit = data_width'(seed);

    logic                   adv;
    logic                   src_valid;
    logic [data_width-1:0]  src_a;
    logic [data_width-1:0]  src_b;
    logic [OP_WIDTH-1:0]    src_op;
    logic [data_width-1:0]  alu_r;
    logic                   alu_flag;

    logic [pipe_stages-1:0] valid_q;
    logic [pipe_stages-1:0] flag_q;
    logic [data_width-1:0]  r_q [pipe_stages];

    logic [data_width-1:0]  gen_cnt_q;
    logic [OPCNT_WIDTH-1:0] op_cnt_q;
    logic [cnt_width-1:0]   flag_count_q;

    // Whole pipeline moves in lockstep whenever the output slot is free or drained.
    assign adv      = !valid_q[pipe_stages-1] || out_ready;
    assign in_ready = adv && !gen_en;

    // Pick one source per beat; the generator is always ready with data.
    always_comb begin
        src_valid = in_valid;
        src_a     = in_a;
        src_b     = in_b;
        src_op    = in_op;
        if (gen_en) begin
            src_valid = 1'b1;
            src_a     = gen_cnt_q;
            src_b     = {gen_cnt_q[data_width-2:0], gen_cnt_q[data_width-1]};
            src_op    = {1'b0, op_cnt_q};
        end
    end

    alu_stream_core #(
        .data_width(data_width)
    ) u_core (
        .a   (src_a),
        .b   (src_b),
        .op  (src_op),
        .r   (alu_r),
        .flag(alu_flag)
    );

    // Pipeline registers; data only moves behind a valid beat so bubbles keep old values.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            flag_q  <= '0;
            for (int i = 0; i < int'(pipe_stages); i++) begin
                r_q[i] <= '0;
            end
        end else if (adv) begin
            valid_q[0] <= src_valid;
            if (src_valid) begin
                r_q[0]    <= alu_r;
                flag_q[0] <= alu_flag;
            end
            for (int i = 1; i < int'(pipe_stages); i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) begin
                    r_q[i]    <= r_q[i-1];
                    flag_q[i] <= flag_q[i-1];
                end
            end
        end
    end

    // Operand generator: op cycles 0..7, operand steps once per full op sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            gen_cnt_q <= SeedInit;
            op_cnt_q  <= '0;
        end else if (gen_en && adv) begin
            op_cnt_q <= op_cnt_q + 1'b1;
            if (op_cnt_q == '1) begin
                gen_cnt_q <= gen_cnt_q + 1'b1;
            end
        end
    end

    // Saturating count of delivered results with flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_count_q <= '0;
        end else if (out_valid && out_ready && flag && (flag_count_q != '1)) begin
            flag_count_q <= flag_count_q + 1'b1;
        end
    end

    assign out_valid  = valid_q[pipe_stages-1];
    assign R          = r_q[pipe_stages-1];
    assign flag       = flag_q[pipe_stages-1];
    assign flag_count = flag_count_q;

endmodule

// File: tb/tb_alu_stream.sv
// Directed self-checking bench for alu_stream (two pipe stages, 4-bit flag counter).
module tb_alu_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        gen_en;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [3:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res;
    logic        flag;
    logic [3:0]  flag_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] sweep_r [9] = '{32'd10, 32'd0, 32'd5, 32'd5, 32'd0, 32'd160, 32'd0, 32'd0,
                                 32'd0};
    logic        sweep_f [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] gen_r   [9] = '{32'd3, 32'hFFFF_FFFF, 32'd0, 32'd3, 32'd3, 32'd4, 32'd0,
                                 32'd1, 32'd6};
    logic        gen_f   [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    alu_stream #(
        .data_width (32),
        .pipe_stages(2),
        .seed       (1),
        .cnt_width  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .gen_en    (gen_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .R         (res),
        .flag      (flag),
        .flag_count(flag_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int got;
        rst       = 1'b1;
        gen_en    = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        out_ready = 1'b1;
        tick();
        do_reset();

        // Reset state
        check_val("rst_valid", out_valid, 0);
        check_val("rst_r", res, 0);
        check_val("rst_flag", flag, 0);
        check_val("rst_cnt", flag_count, 0);
        check_val("rst_ready", in_ready, 1);

        // Single external ADD with carry out
        in_valid = 1'b1;
        in_a     = 32'hFFFF_FFFF;
        in_b     = 32'h2;
        in_op    = 4'd0;
        tick();
        in_valid = 1'b0;
        check_val("add_early", out_valid, 0);
        tick();
        check_val("add_valid", out_valid, 1);
        check_val("add_r", res, 32'h1);
        check_val("add_flag", flag, 1);
        tick();
        check_val("add_cnt", flag_count, 1);
        check_val("add_drain", out_valid, 0);

        // Back-to-back opcode sweep 0..8 with A=B=5
        for (int k = 0; k < 9; k++) begin
            in_valid = 1'b1;
            in_a     = 32'd5;
            in_b     = 32'd5;
            in_op    = 4'(k);
            tick();
            if (k > 0) begin
                check_val($sformatf("sweep_v%0d", k - 1), out_valid, 1);
                check_val($sformatf("sweep_r%0d", k - 1), res, sweep_r[k-1]);
                check_val($sformatf("sweep_f%0d", k - 1), flag, sweep_f[k-1]);
            end
        end
        in_valid = 1'b0;
        tick();
        check_val("sweep_r8", res, sweep_r[8]);
        check_val("sweep_f8", flag, sweep_f[8]);
        tick();
        check_val("sweep_cnt", flag_count, 5);

        // Backpressure: six ADD beats, output stalled for four cycles
        do_reset();
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            out_ready = !(cyc >= 3 && cyc < 7);
            in_valid  = (sent < 6);
            in_a      = 32'(sent + 1);
            in_b      = 32'd100;
            in_op     = 4'd0;
            #1;
            if (out_valid && !out_ready) begin
                check_val("bp_stall_ready", in_ready, 0);
                check_val("bp_stall_r", res, 32'(got + 101));
            end
            if (out_valid && out_ready) begin
                check_val($sformatf("bp_r%0d", got), res, 32'(got + 101));
                got++;
            end
            if (in_valid && in_ready) begin
                sent++;
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_val("bp_delivered", 64'(got), 6);
        check_val("bp_sent", 64'(sent), 6);

        // Internal generator from seed 1
        gen_en = 1'b1;
        do_reset();
        tick();
        for (int k = 0; k < 9; k++) begin
            tick();
            check_val($sformatf("gen_v%0d", k), out_valid, 1);
            check_val($sformatf("gen_r%0d", k), res, gen_r[k]);
            check_val($sformatf("gen_f%0d", k), flag, gen_f[k]);
        end

        // Reset with two beats in flight; generator restarts from seed, op 0
        do_reset();
        check_val("mid_rst_valid", out_valid, 0);
        check_val("mid_rst_cnt", flag_count, 0);
        tick();
        check_val("mid_rst_gap", out_valid, 0);
        tick();
        check_val("restart_v", out_valid, 1);
        check_val("restart_r0", res, 32'd3);
        check_val("restart_f0", flag, 0);
        tick();
        check_val("restart_r1", res, 32'hFFFF_FFFF);

        // Saturation: 20 illegal opcodes against a 4-bit counter
        gen_en = 1'b0;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            in_valid = 1'b1;
            in_a     = 32'd7;
            in_b     = 32'd3;
            in_op    = 4'd9;
            tick();
        end
        in_valid = 1'b0;
        check_val("ill_r", res, 0);
        check_val("ill_f", flag, 1);
        tick();
        tick();
        tick();
        check_val("sat_cnt", flag_count, 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
